screen_scroll_ctrl: RTL and testbench

Sequencing controller placed in front of `screen_driver`. It latches the number to display, keeps `screen_driver` in automatic shift mode while idle, and, when scrolling is requested, takes over the shift amount. In scroll mode it steps the image across the display at a fixed rate, dwelling at each end. It also produces a blink/blank strobe for error indication.

---
 rtl/calc_pkg.sv | 16 +
 rtl/screen_scroll_ctrl_step_timer.sv | 33 +++
 rtl/screen_scroll_ctrl.sv | 126 ++++++++++++
 tb/tb_screen_scroll_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared number, shift and scroll-state types for the calculator display path
package calc_pkg;

  localparam int NumDigits = 4;

  typedef logic [4*NumDigits-1:0] num_t;
  typedef logic [2:0]             shift_t;

  typedef enum logic [1:0] {
    IDLE,
    DWELL_START,
    STEP,
    DWELL_END
  } scroll_state_e;

endpackage

// File: rtl/screen_scroll_ctrl_step_timer.sv
// rtl/screen_scroll_ctrl_step_timer.sv - modulo-StepCycles counter with clear, ticking on the last count
module step_timer #(
  parameter int unsigned StepCycles = 12_500_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  output logic tick_o
);

  localparam int unsigned CntW = (StepCycles > 1) ? $clog2(StepCycles) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(StepCycles - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LastCnt);

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (clear_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/screen_scroll_ctrl.sv
// rtl/screen_scroll_ctrl.sv - latches the displayed number, drives scroll shift override and blink blanking
module screen_scroll_ctrl
  import calc_pkg::*;
#(
  parameter int unsigned StepCycles = 12_500_000,
  parameter int unsigned DwellSteps = 2,
  parameter shift_t      MaxShift   = 3'd7
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  num_t   num_i,
  input  logic   num_valid_i,
  input  logic   scroll_en_i,
  input  logic   blink_i,
  output num_t   num_o,
  output logic   override_shift_amount_o,
  output logic   [2:0] new_shift_amount_o,
  output logic   blank_o
);

  localparam int unsigned DwellW = (DwellSteps > 1) ? $clog2(DwellSteps) : 1;
  localparam logic [DwellW-1:0] LastDwell = DwellW'(DwellSteps - 1);

  scroll_state_e     state_q, state_d;
  num_t              num_q, num_d;
  shift_t            shift_q, shift_d, shift_inc;
  logic              override_q, override_d;
  logic [DwellW-1:0] dwell_q, dwell_d;
  logic              blank_q, blank_d;
  logic              scroll_clr, scroll_tick, blink_tick;

  step_timer #(.StepCycles(StepCycles)) u_scroll_timer (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (scroll_clr),
    .tick_o  (scroll_tick)
  );

  step_timer #(.StepCycles(StepCycles)) u_blink_timer (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (~blink_i),
    .tick_o  (blink_tick)
  );

  assign shift_inc = shift_q + 3'd1;

  // Priority in scroll states: scroll_en drop, then reload restart, then step event.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    override_d = override_q;
    dwell_d    = dwell_q;
    scroll_clr = 1'b0;
    num_d      = num_valid_i ? num_i : num_q;

    if (state_q == IDLE || !scroll_en_i || num_valid_i) begin
      shift_d    = '0;
      dwell_d    = '0;
      scroll_clr = 1'b1;
      override_d = scroll_en_i;
      state_d    = scroll_en_i ? DWELL_START : IDLE;
    end else if (scroll_tick) begin
      unique case (state_q)
        DWELL_START: begin
          if (dwell_q == LastDwell) begin
            dwell_d = '0;
            shift_d = shift_inc;
            state_d = (shift_inc == MaxShift) ? DWELL_END : STEP;
          end else begin
            dwell_d = dwell_q + DwellW'(1);
          end
        end
        STEP: begin
          shift_d = shift_inc;
          if (shift_inc == MaxShift) begin
            state_d = DWELL_END;
          end
        end
        DWELL_END: begin
          if (dwell_q == LastDwell) begin
            dwell_d = '0;
            shift_d = '0;
            state_d = DWELL_START;
          end else begin
            dwell_d = dwell_q + DwellW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    blank_d = blank_q;
    if (!blink_i) begin
      blank_d = 1'b0;
    end else if (blink_tick) begin
      blank_d = ~blank_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      num_q      <= '0;
      shift_q    <= '0;
      override_q <= 1'b0;
      dwell_q    <= '0;
      blank_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      shift_q    <= shift_d;
      override_q <= override_d;
      dwell_q    <= dwell_d;
      blank_q    <= blank_d;
    end
  end

  assign num_o                   = num_q;
  assign override_shift_amount_o = override_q;
  assign new_shift_amount_o      = shift_q;
  assign blank_o                 = blank_q & blink_i;

endmodule

// File: tb/tb_screen_scroll_ctrl.sv
// tb/tb_screen_scroll_ctrl.sv - randomized and directed bench for screen_scroll_ctrl against a timeline model
module tb_screen_scroll_ctrl;
  import calc_pkg::*;

  localparam int SC = 4;
  localparam int DW = 2;
  localparam int MS = 7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  num_t       num_in = '0;
  logic       nv = 1'b0;
  logic       en = 1'b0;
  logic       blink = 1'b0;
  num_t       num_o;
  logic       ovr;
  logic [2:0] sh;
  logic       blank;

  int checks = 0;
  int errors = 0;

  // Model: scroll position is just "cycles since the sequence (re)started".
  num_t m_num = '0;
  bit   m_active = 0;
  int   m_t = 0;
  int   m_bt = 0;

  always #5 clk = ~clk;

  screen_scroll_ctrl #(
    .StepCycles (SC),
    .DwellSteps (DW),
    .MaxShift   (3'(MS))
  ) dut (
    .clk_i                   (clk),
    .rst_ni                  (rst_n),
    .num_i                   (num_in),
    .num_valid_i             (nv),
    .scroll_en_i             (en),
    .blink_i                 (blink),
    .num_o                   (num_o),
    .override_shift_amount_o (ovr),
    .new_shift_amount_o      (sh),
    .blank_o                 (blank)
  );

  function automatic int shift_at(int t);
    int p;
    p = (t / SC) % (2*DW + MS - 1);
    if (p < DW) return 0;
    if (p < DW + MS - 1) return p - DW + 1;
    return MS;
  endfunction

  function automatic int exp_sh();
    return m_active ? shift_at(m_t) : 0;
  endfunction

  function automatic logic exp_blank();
    return blink && (((m_bt / SC) % 2) == 1);
  endfunction

  task automatic cycle();
    @(posedge clk);
    if (!rst_n) begin
      m_num = '0; m_active = 0; m_t = 0; m_bt = 0;
    end else begin
      if (nv) m_num = num_in;
      if (!en) begin
        m_active = 0; m_t = 0;
      end else if (!m_active || nv) begin
        m_active = 1; m_t = 0;
      end else begin
        m_t++;
      end
      if (!blink) m_bt = 0;
      else m_bt++;
    end
    #1;
  endtask

  task automatic wait_shift(int target, bit on_tick);
    bit found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (m_active && shift_at(m_t) == target && (!on_tick || (m_t % SC) == SC - 1)) found = 1;
      else cycle();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL wait_shift: shift %0d never reached, last model t %0d", target, m_t);
    end
  endtask

  task automatic test_reset();
    #1;
    checks += 4;
    if (num_o !== '0) begin errors++; $display("FAIL reset_num: got %0d expected 0", num_o); end
    if (ovr !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b expected 0", ovr); end
    if (sh !== 3'd0) begin errors++; $display("FAIL reset_shift: got %0d expected 0", sh); end
    if (blank !== 1'b0) begin errors++; $display("FAIL reset_blank: got %b expected 0", blank); end
    cycle();
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_load_idle();
    en = 1'b0; num_in = 16'd1234; nv = 1'b1;
    cycle();
    nv = 1'b0;
    checks += 2;
    if (num_o !== 16'd1234) begin errors++; $display("FAIL load_idle_num: got %0d expected 1234", num_o); end
    if (ovr !== 1'b0) begin errors++; $display("FAIL load_idle_ovr: got %b expected 0", ovr); end
  endtask

  task automatic test_scroll();
    en = 1'b1;
    cycle();
    checks++;
    if (ovr !== 1'b1) begin errors++; $display("FAIL scroll_start: got %b expected 1", ovr); end
    for (int i = 0; i < 80; i++) begin
      cycle();
      checks += 2;
      if (ovr !== m_active) begin errors++; $display("FAIL scroll_ovr: t %0d got %b expected %b", m_t, ovr, m_active); end
      if (sh !== 3'(exp_sh())) begin errors++; $display("FAIL scroll_shift: t %0d got %0d expected %0d", m_t, sh, exp_sh()); end
    end
  endtask

  task automatic test_restart(bit on_tick);
    en = 1'b1;
    wait_shift(4, on_tick);
    num_in = 16'd5678; nv = 1'b1;
    cycle();
    nv = 1'b0;
    checks += 3;
    if (num_o !== 16'd5678) begin errors++; $display("FAIL restart_num: got %0d expected 5678", num_o); end
    if (sh !== 3'd0) begin errors++; $display("FAIL restart_shift: tick %0d got %0d expected 0", on_tick, sh); end
    if (ovr !== 1'b1) begin errors++; $display("FAIL restart_ovr: got %b expected 1", ovr); end
    for (int i = 0; i < 12; i++) begin
      cycle();
      checks++;
      if (sh !== 3'(exp_sh())) begin errors++; $display("FAIL restart_dwell: t %0d got %0d expected %0d", m_t, sh, exp_sh()); end
    end
  endtask

  task automatic test_drop();
    wait_shift(3, 1'b0);
    en = 1'b0;
    cycle();
    checks += 2;
    if (ovr !== 1'b0) begin errors++; $display("FAIL drop_ovr: got %b expected 0", ovr); end
    if (sh !== 3'd0) begin errors++; $display("FAIL drop_shift: got %0d expected 0", sh); end
    en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cycle();
      checks += 2;
      if (ovr !== 1'b1) begin errors++; $display("FAIL reraise_ovr: got %b expected 1", ovr); end
      if (sh !== 3'(exp_sh())) begin errors++; $display("FAIL reraise_shift: t %0d got %0d expected %0d", m_t, sh, exp_sh()); end
    end
  endtask

  task automatic test_reset_mid_scroll();
    en = 1'b1;
    wait_shift(5, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checks += 4;
    if (num_o !== '0) begin errors++; $display("FAIL midrst_num: got %0d expected 0", num_o); end
    if (ovr !== 1'b0) begin errors++; $display("FAIL midrst_ovr: got %b expected 0", ovr); end
    if (sh !== 3'd0) begin errors++; $display("FAIL midrst_shift: got %0d expected 0", sh); end
    if (blank !== 1'b0) begin errors++; $display("FAIL midrst_blank: got %b expected 0", blank); end
    en = 1'b0;
    cycle();
    rst_n = 1'b1;
    cycle();
    checks += 2;
    if (ovr !== 1'b0) begin errors++; $display("FAIL postrst_ovr: got %b expected 0", ovr); end
    if (sh !== 3'd0) begin errors++; $display("FAIL postrst_shift: got %0d expected 0", sh); end
  endtask

  task automatic test_blink();
    blink = 1'b1;
    for (int i = 0; i < 13; i++) begin
      cycle();
      checks++;
      if (blank !== exp_blank()) begin errors++; $display("FAIL blink_toggle: n %0d got %b expected %b", m_bt, blank, exp_blank()); end
    end
    blink = 1'b0;
    #1;
    checks++;
    if (blank !== 1'b0) begin errors++; $display("FAIL blink_clear: got %b expected 0", blank); end
    cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(49) == 0) en = ~en;
      if ($urandom_range(79) == 0) blink = ~blink;
      nv = ($urandom_range(39) == 0);
      num_in = num_t'($urandom);
      cycle();
      checks += 4;
      if (num_o !== m_num) begin errors++; $display("FAIL rand_num: i %0d got %0d expected %0d", i, num_o, m_num); end
      if (ovr !== m_active) begin errors++; $display("FAIL rand_ovr: i %0d got %b expected %b", i, ovr, m_active); end
      if (sh !== 3'(exp_sh())) begin errors++; $display("FAIL rand_shift: i %0d got %0d expected %0d", i, sh, exp_sh()); end
      if (blank !== exp_blank()) begin errors++; $display("FAIL rand_blank: i %0d got %b expected %b", i, blank, exp_blank()); end
    end
    nv = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_idle();
    test_scroll();
    test_restart(1'b0);
    test_restart(1'b1);
    test_drop();
    test_reset_mid_scroll();
    test_blink();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
